serializer_arbiter: RTL and testbench
=====================================

// Module: serializer_arbiter
// PURPOSE
//  Shares one serializer between NREQ requesters (e.g. completion sources) with round-robin arbitration.
//  Each requester has a one-entry holding slot. The block sequences the serializer handshake:
//  present a command, detect acceptance, wait for shift-out to finish, then pick the next command.
//  Sits between the request/complete queues and the serializer (valid_in/opcode/addr/ready_out).
// PARAMETERS
//  NREQ     4  number of requesters (>=2)
//  ADDRW    8  address width, matches serializer
//  OPCODEW  2  opcode width, matches serializer
// PORTS
//  clk         in   1               system clock; single clock domain
//  rst_n       in   1               reset, synchronous, active-low
//  req_valid   in   NREQ            per-requester command valid
//  req_opcode  in   NREQ*OPCODEW    requester i uses bits [i*OPCODEW +: OPCODEW]
//  req_addr    in   NREQ*ADDRW      requester i uses bits [i*ADDRW +: ADDRW]
//  req_ready   out  NREQ            slot i empty; push happens when req_valid[i] & req_ready[i]
//  ser_valid   out  1               to serializer valid_in
//  ser_opcode  out  OPCODEW         to serializer opcode; registered
//  ser_addr    out  ADDRW           to serializer addr; registered
//  ser_ready   in   1               from serializer ready_out
//  grant_id    out  clog2(NREQ)     index of the command currently owning the serializer
//  busy        out  1               FSM not in IDLE
//  done        out  1               one-cycle pulse: transfer of grant_id finished
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - All slots empty, so req_ready = all 1s.
//   - ser_valid=0, ser_opcode=0, ser_addr=0, grant_id=0, busy=0, done=0.
//   - rr_ptr=0, FSM=IDLE.
//   - Reset mid-transfer abandons it. The serializer's reset must be driven from the same rst_n.
//  Slots:
//   - req_ready[i] = ~full[i], driven from a register.
//   - A push captures opcode/addr and sets full[i] on the next edge.
//   - A slot cleared in cycle t shows req_ready=1 in t+1. There is no same-cycle refill.
//  Arbitration (IDLE only, evaluated when ser_ready=1 and any full):
//   - Pick the first full slot at or after rr_ptr, wrapping modulo NREQ.
//   - Latch grant_id and drive ser_opcode/ser_addr from that slot.
//   - ser_valid<=1, busy<=1; go to ISSUE.
//   - rr_ptr <= grant+1, wrapping NREQ-1 -> 0.
//   - If ser_ready=0 in IDLE, nothing is issued.
//  FSM:
//   - IDLE  -> ISSUE on grant, as described above.
//   - ISSUE: hold ser_valid/opcode/addr stable while ser_ready=1.
//     When ser_ready is sampled 0 (serializer accepted): ser_valid<=0, clear full[grant_id], go to SHIFT.
//     No timeout; ISSUE is held indefinitely while n_cs is high or no SPI edge occurs.
//   - SHIFT: wait for ser_ready=1. Then done<=1 for one cycle, busy<=0, go to IDLE.
//   - A new grant is evaluated in the cycle after done, earliest. Back-to-back transfers therefore have >=1 idle cycle.
//  Simultaneous events:
//   - A push to slot j while j is granted is impossible, because full[j]=1.
//   - A push to other slots during ISSUE/SHIFT is accepted normally.
//   - Pushes arriving in the same cycle as an arbitration are not visible to that arbitration.
//  Ordering: per-requester order is preserved. Across requesters the order is strict round-robin; there is no starvation.
//  Widths: grant_id and rr_ptr use clog2(NREQ) bits. Wrap is an explicit compare against NREQ-1, never a power-of-2 overflow.
// TESTING
//  1. Reset, then push only req0 (op=2'b10, addr=8'hA5). Require:
//     ser_valid=1 with those values; serializer shifts 10_10100101;
//     done pulses once, grant_id=0; req_ready[0]=1 again.
//  2. Fill all 4 slots in one cycle. Require grants in order 0,1,2,3 with exactly 4 done pulses.
//     Re-fill only 1 and 3 with rr_ptr=0: grant 1 then 3.
//  3. With rr_ptr=2, fill slots 0 and 3. Require grant 3 first, then 0 (wrap).
//  4. Hold n_cs high while req2 is full. Require ser_valid held at 1, stable data, FSM in ISSUE, no done.
//     Release n_cs: transfer completes.
//  5. Push req1 while req0 is in SHIFT. Require the req1 push accepted that cycle, and req1 granted right after req0's done.
//  6. Assert rst_n=0 in SHIFT with 2 slots full. Require all outputs at reset values on the next edge,
//     req_ready all 1s, and no done pulse afterwards.

Source files
------------

// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//
// Purpose:
//    Shares one serializer between NREQ requesters using round-robin
//    arbitration. Each requester owns a one-entry holding slot. The block
//    presents a command to the serializer, waits for it to be accepted
//    (ser_ready drops), waits for the shift-out to finish (ser_ready rises
//    again), pulses done, and only then considers the next command.
//
// Ports:
//    clk         system clock, single clock domain
//    rst_n       synchronous active-low reset
//    req_valid   per-requester command valid
//    req_opcode  requester i uses bits [i*OPCODEW +: OPCODEW]
//    req_addr    requester i uses bits [i*ADDRW +: ADDRW]
//    req_ready   slot i is empty; a push happens on req_valid[i] & req_ready[i]
//    ser_valid   command valid towards the serializer
//    ser_opcode  registered opcode towards the serializer
//    ser_addr    registered address towards the serializer
//    ser_ready   ready from the serializer (low while it is busy shifting)
//    grant_id    index of the requester currently owning the serializer
//    busy        high whenever the sequencer is not idle
//    done        one-cycle pulse when the transfer of grant_id has finished
// -----------------------------------------------------------------------------
module serializer_arbiter #(
   parameter int NREQ    = 4,
   parameter int ADDRW   = 8,
   parameter int OPCODEW = 2,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*OPCODEW-1:0]  req_opcode,
   input  logic [NREQ*ADDRW-1:0]    req_addr,
   output logic [NREQ-1:0]          req_ready,
   output logic                     ser_valid,
   output logic [OPCODEW-1:0]       ser_opcode,
   output logic [ADDRW-1:0]         ser_addr,
   input  logic                     ser_ready,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [NREQ-1:0]      full;
   logic [OPCODEW-1:0]   slot_opcode [NREQ];
   logic [ADDRW-1:0]     slot_addr   [NREQ];

   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       rr_ptr_d;
   logic [IDW-1:0]       grant_d;
   logic                 ser_valid_d;
   logic [OPCODEW-1:0]   ser_opcode_d;
   logic [ADDRW-1:0]     ser_addr_d;
   logic                 busy_d;
   logic                 done_d;
   logic                 clear_slot;

   logic                 pick_found;
   logic [IDW-1:0]       pick_idx;
   logic [IDW-1:0]       scan_idx;
   logic [IDW-1:0]       pick_next;

   // The ready flags are simply the inverse of the registered full flags, so a
   // slot emptied by an acceptance only advertises itself one cycle later and
   // can never be refilled in the same cycle it is cleared.
   assign req_ready = ~full;

   // Round-robin search: walk the slots starting at rr_ptr and take the first
   // full one. The index wraps by an explicit compare with NREQ-1 so the
   // search stays correct for requester counts that are not a power of two.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr;
      scan_idx   = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_found && full[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
         scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
      end
      pick_next = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   // Sequencer next-state logic. Every registered output holds its value by
   // default; IDLE grants when the serializer is ready and some slot is full,
   // ISSUE waits for the serializer to drop ready (its acceptance), SHIFT
   // waits for ready to return and then reports completion with done.
   always_comb begin
      state_d      = state_q;
      ser_valid_d  = ser_valid;
      ser_opcode_d = ser_opcode;
      ser_addr_d   = ser_addr;
      grant_d      = grant_id;
      busy_d       = busy;
      done_d       = 1'b0;
      rr_ptr_d     = rr_ptr;
      clear_slot   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ser_ready && pick_found) begin
               grant_d      = pick_idx;
               ser_opcode_d = slot_opcode[pick_idx];
               ser_addr_d   = slot_addr[pick_idx];
               ser_valid_d  = 1'b1;
               busy_d       = 1'b1;
               rr_ptr_d     = pick_next;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (!ser_ready) begin
               ser_valid_d = 1'b0;
               clear_slot  = 1'b1;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer and output registers. Reset abandons any transfer in flight;
   // the serializer is expected to share the same reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ser_valid  <= 1'b0;
         ser_opcode <= '0;
         ser_addr   <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rr_ptr     <= '0;
      end else begin
         state_q    <= state_d;
         ser_valid  <= ser_valid_d;
         ser_opcode <= ser_opcode_d;
         ser_addr   <= ser_addr_d;
         grant_id   <= grant_d;
         busy       <= busy_d;
         done       <= done_d;
         rr_ptr     <= rr_ptr_d;
      end
   end

   // Slot occupancy. A slot is cleared when the serializer accepts the granted
   // command and set by a push into an empty slot. The granted slot is full,
   // so a push and a clear can never target the same slot in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (clear_slot && (grant_id == IDW'(i))) begin
               full[i] <= 1'b0;
            end else if (req_valid[i] && !full[i]) begin
               full[i] <= 1'b1;
            end
         end
      end
   end

   // Slot payload capture. The payload only matters while the slot is full,
   // so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && !full[i]) begin
            slot_opcode[i] <= req_opcode[i*OPCODEW +: OPCODEW];
            slot_addr[i]   <= req_addr[i*ADDRW +: ADDRW];
         end
      end
   end

endmodule

// File: tb/tb_serializer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serializer_arbiter
//
// Purpose:
//    Self-checking bench for serializer_arbiter. A small serializer model
//    shifts accepted commands out MSB first; a reference model predicts the
//    round-robin completion order when commands are issued, and a monitor
//    compares every done pulse against the head of the expected queue.
//
// Ports:
//    none (top-level bench)
// -----------------------------------------------------------------------------
module tb_serializer_arbiter;

   localparam int NREQ    = 4;
   localparam int ADDRW   = 8;
   localparam int OPCODEW = 2;
   localparam int WORDW   = OPCODEW + ADDRW;

   typedef struct {
      int               id;
      logic [WORDW-1:0] word;
   } exp_t;

   logic                    clk;
   logic                    rst_n;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*OPCODEW-1:0] req_opcode;
   logic [NREQ*ADDRW-1:0]   req_addr;
   logic [NREQ-1:0]         req_ready;
   logic                    ser_valid;
   logic [OPCODEW-1:0]      ser_opcode;
   logic [ADDRW-1:0]        ser_addr;
   logic                    ser_ready;
   logic [1:0]              grant_id;
   logic                    busy;
   logic                    done;

   logic                    hold;
   logic [WORDW-1:0]        sh_reg;
   logic [WORDW-1:0]        rx_word;
   logic [WORDW-1:0]        last_word;
   int                      sh_cnt;

   exp_t                    sb[$];
   int                      model_rr;
   logic [OPCODEW-1:0]      next_op   [NREQ];
   logic [ADDRW-1:0]        next_addr [NREQ];

   int                      total;
   int                      bad;
   int                      done_count;

   serializer_arbiter #(
      .NREQ    (NREQ),
      .ADDRW   (ADDRW),
      .OPCODEW (OPCODEW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_opcode (req_opcode),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .ser_valid  (ser_valid),
      .ser_opcode (ser_opcode),
      .ser_addr   (ser_addr),
      .ser_ready  (ser_ready),
      .grant_id   (grant_id),
      .busy       (busy),
      .done       (done)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serializer stand-in: while ready it accepts a valid command unless hold
   // (chip-select held inactive) blocks it, then shifts the word out MSB first
   // one bit per cycle, rebuilding it in rx_word, and raises ready again.
   always @(posedge clk) begin
      if (!rst_n) begin
         ser_ready <= 1'b1;
         sh_cnt    <= 0;
      end else if (ser_ready) begin
         if (ser_valid && !hold) begin
            ser_ready <= 1'b0;
            sh_reg    <= {ser_opcode, ser_addr};
            rx_word   <= '0;
            sh_cnt    <= WORDW;
         end
      end else begin
         rx_word <= {rx_word[WORDW-2:0], sh_reg[WORDW-1]};
         sh_reg  <= sh_reg << 1;
         sh_cnt  <= sh_cnt - 1;
         if (sh_cnt == 1) begin
            ser_ready <= 1'b1;
            last_word <= {rx_word[WORDW-2:0], sh_reg[WORDW-1]};
         end
      end
   end

   // One comparison: counts it and reports a failure line if it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: all slots in mask become visible to one arbitration,
   // so they are served in round-robin order starting at the model pointer,
   // and the pointer ends one past the last slot served.
   task automatic modelRound(input logic [NREQ-1:0] mask);
      int   last;
      exp_t e;
      last = model_rr;
      for (int k = 0; k < NREQ; k++) begin
         int id;
         id = (model_rr + k) % NREQ;
         if (mask[id]) begin
            e.id   = id;
            e.word = {next_op[id], next_addr[id]};
            sb.push_back(e);
            last = id;
         end
      end
      model_rr = (last + 1) % NREQ;
   endtask

   task automatic randomizeData();
      for (int i = 0; i < NREQ; i++) begin
         next_op[i]   = OPCODEW'($urandom);
         next_addr[i] = ADDRW'($urandom);
      end
   endtask

   // Pushes the slots in mask for exactly one clock edge, optionally
   // recording the predicted completions.
   task automatic applyStimulus(input logic [NREQ-1:0] mask, input bit predict);
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]                   = mask[i];
         req_opcode[i*OPCODEW +: OPCODEW] = next_op[i];
         req_addr[i*ADDRW +: ADDRW]     = next_addr[i];
      end
      if (predict) modelRound(mask);
      @(negedge clk);
      req_valid = '0;
   endtask

   // Waits until every predicted transfer has completed and the block is idle.
   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || req_ready != '1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sb.size());
      end
      @(negedge clk);
   endtask

   // Waits for the granted command to be accepted (sequencer in SHIFT).
   task automatic waitShift(input int budget);
      int n;
      n = 0;
      while (!(busy && !ser_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("[TB] FAIL shift_timeout actual=%0d required=1", busy && !ser_valid);
      end
   endtask

   // Monitor: every done pulse must match the oldest predicted completion.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_count++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done actual=grant%0d required=none", grant_id);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("done_grant_id", 32'(grant_id), 32'(e.id));
            checkOutput("shifted_word", 32'(last_word), 32'(e.word));
         end
      end
   end

   // Safety net against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence: directed scenarios followed by random rounds.
   initial begin
      int   dc;
      int   n;
      bit   stable;
      logic [OPCODEW-1:0] held_op;
      logic [ADDRW-1:0]   held_addr;

      total      = 0;
      bad        = 0;
      done_count = 0;
      model_rr   = 0;
      hold       = 1'b0;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_opcode = '0;
      req_addr   = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'hF);
      checkOutput("reset_ser_valid", 32'(ser_valid), 0);
      checkOutput("reset_ser_opcode", 32'(ser_opcode), 0);
      checkOutput("reset_ser_addr", 32'(ser_addr), 0);
      checkOutput("reset_grant_id", 32'(grant_id), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single request from requester 0");
      randomizeData();
      next_op[0]   = 2'b10;
      next_addr[0] = 8'hA5;
      dc = done_count;
      applyStimulus(4'b0001, 1'b1);
      n = 0;
      while (!ser_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t1_ser_valid", 32'(ser_valid), 1);
      checkOutput("t1_ser_opcode", 32'(ser_opcode), 32'h2);
      checkOutput("t1_ser_addr", 32'(ser_addr), 32'hA5);
      checkOutput("t1_grant_id", 32'(grant_id), 0);
      waitDrain(200);
      checkOutput("t1_done_count", 32'(done_count - dc), 1);
      checkOutput("t1_req_ready", 32'(req_ready), 32'hF);

      $display("[TB] all four slots filled together, then 1 and 3");
      randomizeData();
      dc = done_count;
      applyStimulus(4'b1111, 1'b1);
      waitDrain(400);
      checkOutput("t2_done_count", 32'(done_count - dc), 4);
      randomizeData();
      applyStimulus(4'b1010, 1'b1);
      waitDrain(300);

      $display("[TB] wrap from pointer 2 over slots 3 and 0");
      randomizeData();
      applyStimulus(4'b0010, 1'b1);
      waitDrain(200);
      randomizeData();
      applyStimulus(4'b1001, 1'b1);
      waitDrain(300);

      $display("[TB] serializer held off while slot 2 is granted");
      randomizeData();
      hold = 1'b1;
      dc   = done_count;
      applyStimulus(4'b0100, 1'b1);
      repeat (2) @(negedge clk);
      held_op   = ser_opcode;
      held_addr = ser_addr;
      stable    = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!ser_valid || ser_opcode != held_op || ser_addr != held_addr || !busy)
            stable = 1'b0;
      end
      checkOutput("t4_hold_stable", 32'(stable), 1);
      checkOutput("t4_ser_valid", 32'(ser_valid), 1);
      checkOutput("t4_ser_opcode", 32'(ser_opcode), 32'(next_op[2]));
      checkOutput("t4_ser_addr", 32'(ser_addr), 32'(next_addr[2]));
      checkOutput("t4_grant_id", 32'(grant_id), 2);
      checkOutput("t4_no_done", 32'(done_count - dc), 0);
      hold = 1'b0;
      waitDrain(200);

      $display("[TB] push to slot 1 while slot 0 shifts");
      randomizeData();
      applyStimulus(4'b0001, 1'b1);
      waitShift(50);
      checkOutput("t5_ready_before", 32'(req_ready[1]), 1);
      applyStimulus(4'b0010, 1'b1);
      checkOutput("t5_push_accepted", 32'(req_ready[1]), 0);
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5_done_seen", 32'(done), 1);
      @(negedge clk);
      checkOutput("t5_next_valid", 32'(ser_valid), 1);
      checkOutput("t5_next_grant", 32'(grant_id), 1);
      waitDrain(200);

      $display("[TB] reset during shift with two slots full");
      randomizeData();
      applyStimulus(4'b0001, 1'b1);
      waitShift(50);
      applyStimulus(4'b0110, 1'b0);
      checkOutput("t6_busy_before", 32'(busy), 1);
      checkOutput("t6_slots_full", 32'(req_ready), 32'h9);
      rst_n = 1'b0;
      @(negedge clk);
      sb.delete();
      model_rr = 0;
      checkOutput("t6_req_ready", 32'(req_ready), 32'hF);
      checkOutput("t6_ser_valid", 32'(ser_valid), 0);
      checkOutput("t6_ser_opcode", 32'(ser_opcode), 0);
      checkOutput("t6_ser_addr", 32'(ser_addr), 0);
      checkOutput("t6_grant_id", 32'(grant_id), 0);
      checkOutput("t6_busy", 32'(busy), 0);
      checkOutput("t6_done", 32'(done), 0);
      dc    = done_count;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("t6_no_done_after", 32'(done_count - dc), 0);
      checkOutput("t6_idle_after", 32'(busy), 0);

      $display("[TB] random rounds");
      for (int r = 0; r < 25; r++) begin
         randomizeData();
         hold = ($urandom_range(0, 3) == 0);
         applyStimulus(NREQ'($urandom_range(1, 15)), 1'b1);
         repeat ($urandom_range(0, 6)) @(negedge clk);
         hold = 1'b0;
         waitDrain(600);
      end

      checkOutput("final_pending", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
